// File: rtl/bldc_pkg.sv
// Shared types and tables for the six-step BLDC commutation sequencer:
// controller states, fault codes, per-step gate masks and Hall decode.
package bldc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DEAD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_HALL  = 2'b01;
    localparam logic [1:0] FC_STALL = 2'b10;

    // Indexed by step; masks are {C,B,A}. Step 0 is A+ B-, step 5 is C+ B-.
    localparam logic [5:0][2:0] STEP_HI_MASK = {3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
    localparam logic [5:0][2:0] STEP_LO_MASK = {3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};

    localparam logic [2:0] HALL_STEP0 = 3'b101;
    localparam logic [2:0] HALL_STEP1 = 3'b100;
    localparam logic [2:0] HALL_STEP2 = 3'b110;
    localparam logic [2:0] HALL_STEP3 = 3'b010;
    localparam logic [2:0] HALL_STEP4 = 3'b011;
    localparam logic [2:0] HALL_STEP5 = 3'b001;

    typedef struct packed {
        logic       valid;
        logic [2:0] step;
    } hall_dec_t;

    function automatic hall_dec_t hall_decode(input logic [2:0] code);
        hall_dec_t d;
        d.valid = 1'b1;
        d.step  = 3'd0;
        case (code)
            HALL_STEP0: d.step = 3'd0;
            HALL_STEP1: d.step = 3'd1;
            HALL_STEP2: d.step = 3'd2;
            HALL_STEP3: d.step = 3'd3;
            HALL_STEP4: d.step = 3'd4;
            HALL_STEP5: d.step = 3'd5;
            default:    d.valid = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] step_reverse(input logic [2:0] s);
        return (s >= 3'd3) ? s - 3'd3 : s + 3'd3;
    endfunction

endpackage

// File: rtl/bldc_hall_sync.sv
// Two-flop Hall synchronizer with an optional stability filter.
// Build option HALL_FILTER_EN: accept a value only after FILT_CYCLES identical samples.
module bldc_hall_sync #(
    parameter int FILT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hall,
    output logic [2:0] hall_s
);

    if (FILT_CYCLES < 1) begin : g_param_err
        $error("bldc_hall_sync: FILT_CYCLES must be >= 1");
    end

    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= hall;
            sync2 <= sync1;
        end
    end

`ifdef HALL_FILTER_EN
    localparam int FW = $clog2(FILT_CYCLES + 1);

    logic [2:0]    last;
    logic [FW-1:0] run_len;
    logic [2:0]    filt;

    // run_len counts how many consecutive samples have matched the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= '0;
            run_len <= '0;
            filt    <= '0;
        end else begin
            last <= sync2;
            if (sync2 != last) begin
                run_len <= FW'(1);
            end else if (run_len != FW'(FILT_CYCLES)) begin
                run_len <= run_len + FW'(1);
            end
            if ((sync2 == last) && (run_len >= FW'(FILT_CYCLES - 1))) begin
                filt <= sync2;
            end
        end
    end

    assign hall_s = filt;
`else
    assign hall_s = sync2;
`endif

endmodule

// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation sequencer: Hall decode, dead-time, invalid-Hall and stall faults.
// Build option HALL_FILTER_EN enables the Hall stability filter in bldc_hall_sync.
//
// state | meaning
// IDLE  | gates off, waiting for en with a valid Hall code
// RUN   | gates driven per step, high side chopped by pwm_in
// DEAD  | gates off for DEADTIME_CYCLES after a step change
// FAULT | gates off, fault latched until fault_clr
module bldc_commutation_ctrl
    import bldc_pkg::*;
#(
    parameter int DEADTIME_CYCLES = 16,
    parameter int STALL_CYCLES    = 1000000,
    parameter int CNT_W           = 20,
    parameter int FILT_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       pwm_in,
    input  logic [2:0] hall,
    input  logic       fault_clr,
    output logic [2:0] gate_hi,
    output logic [2:0] gate_lo,
    output logic [2:0] step,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       busy
);

    if (DEADTIME_CYCLES < 1 || STALL_CYCLES < 2 || STALL_CYCLES >= (1 << CNT_W)) begin : g_param_err
        $error("bldc_commutation_ctrl: bad DEADTIME_CYCLES / STALL_CYCLES / CNT_W");
    end

    logic [2:0]       hall_s;
    hall_dec_t        dec;
    logic [2:0]       dstep;
    state_t           state, state_nxt;
    logic [2:0]       step_nxt;
    logic [CNT_W-1:0] dead_cnt, dead_nxt;
    logic [CNT_W-1:0] stall_cnt, stall_nxt, stall_inc;
    logic             stall_hit;
    logic [1:0]       fc_nxt;
    logic [2:0]       hi_nxt, lo_nxt;

    bldc_hall_sync #(.FILT_CYCLES(FILT_CYCLES)) u_hall_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .hall   (hall),
        .hall_s (hall_s)
    );

    assign dec       = hall_decode(hall_s);
    assign dstep     = dir ? step_reverse(dec.step) : dec.step;
    assign stall_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + CNT_W'(1);
    // Fault lands on the edge where the counter would reach STALL_CYCLES-1
    assign stall_hit = (stall_cnt >= CNT_W'(STALL_CYCLES - 2));

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        dead_nxt  = dead_cnt;
        stall_nxt = '0;
        fc_nxt    = fault_code;
        case (state)
            IDLE: begin
                if (en) begin
                    if (!dec.valid) begin
                        state_nxt = FAULT;
                        fc_nxt    = FC_HALL;
                    end else begin
                        state_nxt = RUN;
                        step_nxt  = dstep;
                    end
                end
            end
            RUN, DEAD: begin
                stall_nxt = stall_inc;
                if (!dec.valid) begin
                    state_nxt = FAULT;
                    fc_nxt    = FC_HALL;
                    stall_nxt = '0;
                end else if (stall_hit) begin
                    state_nxt = FAULT;
                    fc_nxt    = FC_STALL;
                    stall_nxt = '0;
                end else if (!en) begin
                    state_nxt = IDLE;
                    stall_nxt = '0;
                end else if (dstep != step) begin
                    state_nxt = DEAD;
                    step_nxt  = dstep;
                    dead_nxt  = CNT_W'(DEADTIME_CYCLES - 1);
                    stall_nxt = '0;
                end else if (state == DEAD) begin
                    if (dead_cnt == '0) state_nxt = RUN;
                    else                dead_nxt  = dead_cnt - CNT_W'(1);
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_nxt = IDLE;
                    fc_nxt    = FC_NONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        hi_nxt = '0;
        lo_nxt = '0;
        if (state_nxt == RUN) begin
            hi_nxt = STEP_HI_MASK[step_nxt] & {3{pwm_in}};
            lo_nxt = STEP_LO_MASK[step_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            dead_cnt   <= '0;
            stall_cnt  <= '0;
            fault_code <= FC_NONE;
            gate_hi    <= '0;
            gate_lo    <= '0;
            fault      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            dead_cnt   <= dead_nxt;
            stall_cnt  <= stall_nxt;
            fault_code <= fc_nxt;
            gate_hi    <= hi_nxt;
            gate_lo    <= lo_nxt;
            fault      <= (state_nxt == FAULT);
            busy       <= (state_nxt == RUN) || (state_nxt == DEAD);
        end
    end

endmodule

// File: doc/bldc_commutation_ctrl.md
Name: bldc_commutation_ctrl

Overview:
Six-step (trapezoidal) BLDC commutation sequencer. Decodes three Hall sensor inputs into a commutation step. Drives six gate-enable outputs, with the PWM chopping the high side, dead-time on every step change, and latched faults for invalid Hall codes and rotor stall. Sits between the Hall front-end pins and the gate-driver output stage.

Parameters:
DEADTIME_CYCLES, 16, clk cycles with all gates off after any step change; must be >= 1
STALL_CYCLES, 1000000, cycles without a valid Hall change in RUN/DEAD before the stall fault
CNT_W, 20, width of the stall and dead-time counters; must hold STALL_CYCLES
FILT_CYCLES, 4, Hall stability window; used only with HALL_FILTER_EN

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
en  in  1  run request
dir  in  1  0 = forward, 1 = reverse
pwm_in  in  1  PWM, ANDed into the active high-side gate
hall  in  3  raw Hall sensors {C,B,A}, asynchronous to clk
fault_clr  in  1  single-cycle pulse; clears a latched fault
gate_hi  out  3  high-side enables {C,B,A}
gate_lo  out  3  low-side enables {C,B,A}
step  out  3  current commutation step, 0..5
fault  out  1  fault latched
fault_code  out  2  00 none, 01 invalid Hall, 10 stall
busy  out  1  1 in RUN or DEAD

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; state IDLE; counters 0.
- hall passes through a 2-flop synchronizer. Outputs are registered. Latency from a Hall pin edge to the gates going off is 3 clk cycles.
- Forward decode (dir=0), Hall code -> step:
  - 101 -> 0 (A+ B-)
  - 100 -> 1 (A+ C-)
  - 110 -> 2 (B+ C-)
  - 010 -> 3 (B+ A-)
  - 011 -> 4 (C+ A-)
  - 001 -> 5 (C+ B-)
- Reverse (dir=1): applied step = (decoded step + 3) mod 6.
- Hall codes 000 and 111 are invalid.
- Gate drive in RUN:
  - High phase enable = pwm_in.
  - Low phase enable = 1.
  - All other gates 0.
- Invariant: gate_hi[i] & gate_lo[i] is never 1, in any state or cycle.
- States:
  - IDLE: gates 0. Goes to RUN when en=1 and the synced Hall code is valid; step loads from the decode.
  - RUN: gates per step. A change in the decoded step (Hall or dir change) updates step, loads the dead counter and enters DEAD.
  - DEAD: all gates 0 for DEADTIME_CYCLES cycles, then returns to RUN. A further step change while in DEAD reloads the counter with the new step.
  - FAULT: all gates 0; fault=1; fault_code held. Leaves only on fault_clr, going to IDLE. It does not leave on en=0.
- en=0 in RUN or DEAD: go to IDLE the next cycle. fault_code is untouched.
- Invalid Hall code in IDLE (with en=1), RUN or DEAD: go to FAULT with code 01.
- Stall counter:
  - Cleared on every valid step change and whenever outside RUN/DEAD.
  - Reaching STALL_CYCLES-1: go to FAULT with code 10.
- Priority in the same cycle: invalid Hall > stall > en=0 > step change.
- fault_clr outside FAULT is ignored. fault_clr with en=1 still goes to IDLE; RUN is entered on the following cycle if Hall is valid.
- Stall counter saturates and never wraps.
- rst_n asserted mid-operation: gates drop to 0 immediately (asynchronously).

Optional Feature:
HALL_FILTER_EN:
- Defined: a synced Hall value is accepted only after FILT_CYCLES consecutive identical samples. Total latency is 3+FILT_CYCLES cycles. Shorter glitches are ignored, including glitches to invalid codes.
- Undefined: no filter; the synced value is used directly; FILT_CYCLES is unused.

Decomposition:
- Package bldc_pkg holds:
  - state enum (IDLE, RUN, DEAD, FAULT)
  - fault code constants
  - 6-entry step table (hi phase, lo phase)
  - Hall-to-step decode constants
- One sub-module: bldc_hall_sync, containing the 2-flop synchronizer and the optional filter, output 3 bits.

Test Plan:
1. Reset, en=1, pwm_in=1, hall=101 -> RUN; step=0; gate_hi=001; gate_lo=010; busy=1.
2. Forward sequence 101,100,110,010,011,001 -> step 0..5 in order. Each change gives exactly 16 cycles of gates=000. No cycle with hi&lo on the same phase.
3. dir=1, hall=101 -> step=3; gate_hi=010; gate_lo=001.
4. hall=111 in RUN -> FAULT, fault_code=01, gates 0. Remove the bad code and set en=0 -> stays in FAULT. Pulse fault_clr -> IDLE, fault=0.
5. Hall held constant with STALL_CYCLES=100 -> fault_code=10 at cycle 99 after the last change.
6. With HALL_FILTER_EN, a 2-cycle hall=000 glitch -> no fault, step unchanged. Without the macro, the same stimulus -> FAULT with code 01.
